dmem_lsu_ctrl: RTL and testbench
================================

Name: dmem_lsu_ctrl

Overview:
Load/store sequencer between the CPU execute stage and the word-only, combinational-read, synchronous-write data memory. It decodes RV32I load/store width (funct3) and issues aligned word reads and writes. Sub-word stores are performed as read-modify-write, and loaded bytes/halfwords are extracted and sign/zero-extended. Misaligned and out-of-range accesses are detected and reported without touching memory.

Parameters:
SIZE_BYTES, 1024, data memory size in bytes; a legal access satisfies addr + access_size <= SIZE_BYTES.

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  requester has a load/store
req_ready  out  1  controller can accept; high only in IDLE
req_we  in  1  1 = store, 0 = load
req_funct3  in  3  RV32I width: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU (loads); 000 SB, 001 SH, 010 SW (stores)
req_addr  in  32  byte address
req_wdata  in  32  store data (low byte/half used for SB/SH)
resp_valid  out  1  one-cycle completion pulse; no backpressure
resp_rdata  out  32  extended load result; 0 for stores and errors
resp_err  out  1  misaligned / out-of-range / illegal funct3; valid with resp_valid
mem_read  out  1  to data memory
mem_write  out  1  to data memory (full word)
mem_addr  out  32  always word-aligned: {addr[31:2], 2'b00}
mem_wdata  out  32  write word
mem_rdata  in  32  combinational read data from memory

Behaviour:
- Reset (async, rst_n=0): state IDLE; all request fields captured in registers cleared; resp_valid=0, resp_rdata=0, resp_err=0, mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0. req_ready=1 (decoded from IDLE).
- mem_* outputs are decoded from registered state and registered request fields only; no combinational path from req_* to mem_*.
- FSM states: IDLE, RD, WR, RESP.
- IDLE: on req_valid && req_ready, capture we/funct3/addr/wdata. Error check at acceptance: LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0; illegal funct3 (011, 110, 111; also 100/101 for stores); addr + size > SIZE_BYTES. On error go to RESP with err=1 and issue no memory access. Otherwise: load or SB/SH go to RD; SW goes to WR.
- RD (1 cycle): mem_read=1, mem_addr = aligned addr. Capture mem_rdata at clock edge. Load goes to RESP. SB/SH merge: SB replaces lane addr[1:0] with wdata[7:0]; SH replaces half addr[1] with wdata[15:0]. Then go to WR.
- WR (1 cycle): mem_write=1, mem_wdata = merged word (SB/SH) or req_wdata (SW). Then go to RESP.
- RESP (1 cycle): resp_valid=1, resp_err=err flag. resp_rdata = extracted load (LB/LH sign-extend; LBU/LHU zero-extend; LW full word), or 0. Then go to IDLE. req_ready=0 here; the next request is accepted in IDLE the following cycle.
- Latency from accept edge to resp_valid cycle: load = 2 cycles; SW = 2; SB/SH = 3; error = 1.
- Throughput: one outstanding access; req_ready deasserted from RD through RESP.
- mem_read and mem_write are never asserted together. Exactly one mem_write pulse per legal store; zero memory activity for errored requests.
- Reset mid-operation: access is abandoned; a pending WR does not occur if rst_n falls before its edge; no resp_valid is produced.
- req_valid dropped while not ready: ignored, no capture.

Decomposition:
- Package dmem_lsu_pkg: funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU), state enum typedef (IDLE, RD, WR, RESP), access-size function from funct3.
- Sub-module lsu_align (combinational): load extract/extend (rdata, addr[1:0], funct3) and store merge (old word, wdata, addr[1:0], funct3). The FSM remains in dmem_lsu_ctrl.

Test Plan:
- SW addr 0x10 data 0xDEADBEEF, then LW 0x10: one mem_write with mem_addr 0x10; LW resp_rdata=0xDEADBEEF, err=0, resp_valid 2 cycles after accept.
- Memory word 0x80 = 0x11223344; SB addr 0x82 data 0xAB: RD then WR, mem_wdata=0x11AB3344; LBU 0x82 returns 0x000000AB; LB 0x82 returns 0xFFFFFFAB.
- SH addr 0x86 data 0x8001 over word 0 at 0x84: mem_wdata=0x80010000; LH 0x86 returns 0xFFFF8001; LHU 0x86 returns 0x00008001.
- LW 0x13, SH 0x05, funct3=011 load, LW 0x3FE (SIZE_BYTES=1024): each produces resp_err=1, resp_rdata=0, and no mem_read/mem_write, 1 cycle after accept.
- Back-to-back req_valid held high: req_ready low from RD through RESP; second request is accepted only in the IDLE cycle after RESP; mem_read and mem_write are never high together.
- Assert rst_n=0 during RD of an SB: no mem_write, no resp_valid; after release, req_ready=1 and a following LW completes normally.

Source files
------------

// File: rtl/dmem_lsu_pkg.sv
// Shared definitions for the data-memory load/store controller:
// RV32I width encodings, FSM state type and access-size decode.
package dmem_lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RESP = 2'd3
  } lsu_state_e;

  // Bytes touched by an access; 0 marks an encoding with no defined width.
  function automatic logic [2:0] access_size(input logic [2:0] funct3);
    logic [2:0] size;
    case (funct3)
      F3_B, F3_BU: size = 3'd1;
      F3_H, F3_HU: size = 3'd2;
      F3_W:        size = 3'd4;
      default:     size = 3'd0;
    endcase
    return size;
  endfunction

endpackage

// File: rtl/dmem_lsu_ctrl_align.sv
// Lane steering for the load/store controller: extracts and extends loaded
// bytes/halfwords, and merges sub-word store data into an existing word.
module lsu_align
  import dmem_lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [15:0] wdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] load_data,
  output logic [31:0] merge_data
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Select the addressed lane and sign/zero-extend it according to funct3.
  always_comb begin
    byte_s = rdata[{addr_lo, 3'b000} +: 8];
    if (addr_lo[1]) begin
      half_s = rdata[31:16];
    end else begin
      half_s = rdata[15:0];
    end
    case (funct3)
      F3_B:    load_data = {{24{byte_s[7]}}, byte_s};
      F3_BU:   load_data = {24'd0, byte_s};
      F3_H:    load_data = {{16{half_s[15]}}, half_s};
      F3_HU:   load_data = {16'd0, half_s};
      F3_W:    load_data = rdata;
      default: load_data = 32'd0;
    endcase
  end

  // Overlay the store byte/half onto the old word; other widths pass it through.
  always_comb begin
    merge_data = rdata;
    case (funct3)
      F3_B: merge_data[{addr_lo, 3'b000} +: 8] = wdata[7:0];
      F3_H: begin
        if (addr_lo[1]) begin
          merge_data[31:16] = wdata;
        end else begin
          merge_data[15:0] = wdata;
        end
      end
      default: merge_data = rdata;
    endcase
  end

endmodule

// File: rtl/dmem_lsu_ctrl.sv
// Load/store sequencer between the execute stage and a word-wide data memory.
// One access in flight; sub-word stores are done as read-modify-write, and
// illegal requests are answered without touching memory.
module dmem_lsu_ctrl
  import dmem_lsu_pkg::*;
#(
  parameter int unsigned SIZE_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [32:0] SIZE_LIMIT = 33'(SIZE_BYTES);

  lsu_state_e  state_r, state_next_s;
  logic        we_r;
  logic [2:0]  funct3_r;
  logic [31:0] addr_r;
  logic [15:0] wdata_r;
  logic        err_r;
  logic [31:0] data_r;
  logic [31:0] result_r;

  logic [2:0]  req_size_s;
  logic [32:0] req_end_s;
  logic        req_err_s;
  logic [31:0] load_s;
  logic [31:0] merge_s;

  lsu_align u_align (
    .rdata      (mem_rdata),
    .wdata      (wdata_r),
    .addr_lo    (addr_r[1:0]),
    .funct3     (funct3_r),
    .load_data  (load_s),
    .merge_data (merge_s)
  );

  // Classify the incoming request: bad width, misalignment or past the end.
  always_comb begin
    req_size_s = access_size(req_funct3);
    req_end_s  = {1'b0, req_addr} + {30'd0, req_size_s};
    req_err_s  = (req_size_s == 3'd0)
              || (req_we && req_funct3[2])
              || ((req_size_s == 3'd2) && req_addr[0])
              || ((req_size_s == 3'd4) && (req_addr[1:0] != 2'b00))
              || (req_end_s > SIZE_LIMIT);
  end

  // Next-state logic; errors skip memory, full-word stores skip the read.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (!req_valid) begin
          state_next_s = IDLE;
        end else if (req_err_s) begin
          state_next_s = RESP;
        end else if (req_we && (req_funct3 == F3_W)) begin
          state_next_s = WR;
        end else begin
          state_next_s = RD;
        end
      end
      RD: begin
        if (we_r) begin
          state_next_s = WR;
        end else begin
          state_next_s = RESP;
        end
      end
      WR:      state_next_s = RESP;
      RESP:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // State register plus request capture and read-data capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      we_r     <= 1'b0;
      funct3_r <= 3'd0;
      addr_r   <= 32'd0;
      wdata_r  <= 16'd0;
      err_r    <= 1'b0;
      data_r   <= 32'd0;
      result_r <= 32'd0;
    end else begin
      state_r <= state_next_s;
      case (state_r)
        IDLE: begin
          if (req_valid) begin
            we_r     <= req_we;
            funct3_r <= req_funct3;
            addr_r   <= req_addr;
            wdata_r  <= req_wdata[15:0];
            err_r    <= req_err_s;
            data_r   <= req_wdata;
            result_r <= 32'd0;
          end
        end
        RD: begin
          if (we_r) begin
            data_r <= merge_s;
          end else begin
            result_r <= load_s;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded purely from registered state and captured fields.
  always_comb begin
    req_ready  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = 32'd0;
    mem_wdata  = 32'd0;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    resp_rdata = 32'd0;
    case (state_r)
      IDLE: req_ready = 1'b1;
      RD: begin
        mem_read = 1'b1;
        mem_addr = {addr_r[31:2], 2'b00};
      end
      WR: begin
        mem_write = 1'b1;
        mem_addr  = {addr_r[31:2], 2'b00};
        mem_wdata = data_r;
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_err   = err_r;
        resp_rdata = result_r;
      end
      default: req_ready = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_dmem_lsu_ctrl.sv
// Randomized scoreboard bench for dmem_lsu_ctrl with a byte-level memory model.
module tb_dmem_lsu_ctrl;

  localparam int SIZE = 1024;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] dmem [0:255];
  logic [7:0]  refmem [0:SIZE-1];

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  typedef struct { logic [31:0] rdata; logic err; int lat; int acc; } resp_t;
  typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;
  resp_t       resp_q[$];
  wr_t         wr_q[$];
  logic [31:0] rd_q[$];

  dmem_lsu_ctrl #(.SIZE_BYTES(SIZE)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  assign mem_rdata = dmem[mem_addr[9:2]];

  always @(posedge clk) begin
    if (mem_write) dmem[mem_addr[9:2]] <= mem_wdata;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every DUT memory access or response is checked against the queues.
  always @(negedge clk) begin : mon
    resp_t e;
    wr_t w;
    logic [31:0] a;
    if (rst_n) begin
      if (mem_read || mem_write || resp_valid) chk("ready_while_busy", req_ready, 0);
      if (mem_read && mem_write) chk("rd_wr_overlap", mem_write, 0);
      if (mem_read) begin
        if (rd_q.size() == 0) chk("rd_unexpected", mem_read, 0);
        else begin
          a = rd_q.pop_front();
          chk("rd_addr", mem_addr, a);
        end
      end
      if (mem_write) begin
        if (wr_q.size() == 0) chk("wr_unexpected", mem_write, 0);
        else begin
          w = wr_q.pop_front();
          chk("wr_addr", mem_addr, w.addr);
          chk("wr_data", mem_wdata, w.data);
        end
      end
      if (resp_valid) begin
        if (resp_q.size() == 0) chk("resp_unexpected", resp_valid, 0);
        else begin
          e = resp_q.pop_front();
          chk("resp_rdata", resp_rdata, e.rdata);
          chk("resp_err", resp_err, e.err);
          chk("resp_latency", cyc - e.acc + 1, e.lat);
        end
      end
    end
  end

  // Reference behaviour computed from byte-addressed memory and width rules.
  task automatic model(input bit we, input bit [2:0] f3, input bit [31:0] addr,
                       input bit [31:0] wd, input int acc);
    int size;
    bit bad;
    resp_t e;
    wr_t w;
    longint raw;
    int a;
    int base;
    case (f3)
      3'd0, 3'd4: size = 1;
      3'd1, 3'd5: size = 2;
      3'd2:       size = 4;
      default:    size = 0;
    endcase
    bad = (size == 0) || (we && f3 >= 3'd4);
    if (!bad && (addr % size) != 0) bad = 1'b1;
    if (!bad && (longint'(addr) + size > SIZE)) bad = 1'b1;
    e.acc = acc;
    e.rdata = 32'd0;
    e.err = bad;
    if (bad) e.lat = 1;
    else if (we && size < 4) e.lat = 3;
    else e.lat = 2;
    if (!bad) begin
      a = int'(addr);
      base = a - (a % 4);
      if (!we) begin
        raw = 0;
        for (int i = 0; i < size; i++) raw += longint'(refmem[a + i]) << (8 * i);
        if (f3 == 3'd0 && raw >= 128) raw -= 256;
        if (f3 == 3'd1 && raw >= 32768) raw -= 65536;
        e.rdata = raw[31:0];
        rd_q.push_back(32'(base));
      end else begin
        if (size < 4) rd_q.push_back(32'(base));
        for (int i = 0; i < size; i++) refmem[a + i] = wd[8*i +: 8];
        w.addr = 32'(base);
        w.data = {refmem[base+3], refmem[base+2], refmem[base+1], refmem[base]};
        wr_q.push_back(w);
      end
    end
    resp_q.push_back(e);
  endtask

  // Present one request; hold keeps req_valid high after acceptance.
  task automatic issue(input bit we, input bit [2:0] f3, input bit [31:0] addr,
                       input bit [31:0] wd, input bit hold);
    int guard;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    guard = 0;
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) begin
      chk("accept_timeout", req_ready, 1);
      req_valid = 1'b0;
    end else begin
      model(we, f3, addr, wd, cyc + 1);
      @(posedge clk);
      #1;
      if (!hold) req_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((resp_q.size() != 0 || rd_q.size() != 0 || wr_q.size() != 0) && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
    chk("drain_resp", resp_q.size(), 0);
    chk("drain_mem", rd_q.size() + wr_q.size(), 0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      dmem[i] = $urandom;
      {refmem[4*i+3], refmem[4*i+2], refmem[4*i+1], refmem[4*i]} = dmem[i];
    end

    repeat (3) @(negedge clk);
    chk("rst_ready", req_ready, 1);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_rdata", resp_rdata, 0);
    chk("rst_resp_err", resp_err, 0);
    chk("rst_mem_read", mem_read, 0);
    chk("rst_mem_write", mem_write, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    rst_n = 1'b1;

    // Word store/load, sub-word read-modify-write and extension.
    issue(1, 3'd2, 32'h10, 32'hDEADBEEF, 0);
    issue(0, 3'd2, 32'h10, 32'h0, 0);
    issue(1, 3'd2, 32'h80, 32'h11223344, 0);
    issue(1, 3'd0, 32'h82, 32'h000000AB, 0);
    issue(0, 3'd4, 32'h82, 32'h0, 0);
    issue(0, 3'd0, 32'h82, 32'h0, 0);
    issue(1, 3'd2, 32'h84, 32'h0, 0);
    issue(1, 3'd1, 32'h86, 32'h00008001, 0);
    issue(0, 3'd1, 32'h86, 32'h0, 0);
    issue(0, 3'd5, 32'h86, 32'h0, 0);
    issue(0, 3'd2, 32'h84, 32'h0, 0);
    // Errors and range boundaries.
    issue(0, 3'd2, 32'h13, 32'h0, 0);
    issue(1, 3'd1, 32'h05, 32'h1234, 0);
    issue(0, 3'd3, 32'h40, 32'h0, 0);
    issue(0, 3'd2, 32'h3FE, 32'h0, 0);
    issue(1, 3'd4, 32'h20, 32'h55, 0);
    issue(0, 3'd2, 32'h400, 32'h0, 0);
    issue(0, 3'd2, 32'h3FC, 32'h0, 0);
    issue(0, 3'd0, 32'h3FF, 32'h0, 0);
    issue(1, 3'd1, 32'h3FE, 32'hC0DE, 0);
    issue(0, 3'd5, 32'h3FE, 32'h0, 0);
    issue(0, 3'd2, 32'hFFFF_FFFC, 32'h0, 0);
    // Back-to-back with req_valid held high.
    issue(0, 3'd2, 32'h10, 32'h0, 1);
    issue(1, 3'd0, 32'h11, 32'h77, 1);
    issue(1, 3'd2, 32'h30, 32'hCAFEF00D, 1);
    issue(0, 3'd0, 32'h11, 32'h0, 0);
    drain();

    // Reset during the read phase of a byte store.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd0; req_addr = 32'h100; req_wdata = 32'h5A;
    chk("rstmid_ready", req_ready, 1);
    rd_q.push_back(32'h100);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("rstmid_in_rd", mem_read, 1);
    #1;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rstmid_no_write", mem_write, 0);
      chk("rstmid_no_resp", resp_valid, 0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("rstmid_ready_after", req_ready, 1);
    issue(0, 3'd2, 32'h100, 32'h0, 0);
    drain();

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      bit we;
      bit [2:0] f3;
      bit [31:0] addr;
      int r;
      we = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      r = $urandom_range(0, 9);
      if (r == 0) addr = $urandom;
      else if (r == 1) addr = 32'(SIZE - $urandom_range(0, 8));
      else if (r < 6) addr = 32'($urandom_range(0, 63) * 4 + (f3[1] ? 0 : (f3[0] ? 2 * $urandom_range(0, 1) : $urandom_range(0, 3))));
      else addr = 32'($urandom_range(0, SIZE - 1));
      issue(we, f3, addr, $urandom, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) begin
        req_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
    end
    req_valid = 1'b0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
